// File: rtl/ring_router_mux.sv
// ring_router_mux: merges pass-through ring flits and locally injected
// flits onto the next ring hop. Packets are forwarded atomically and the
// two sources alternate (round-robin) at packet boundaries.
// Optional feature: define RING_ROUTER_MUX_OUTREG_EN to drive out_ring from a
// one-entry output register (1-cycle latency, full throughput). Without it
// the output is combinational from the granted source.

package dii_pkg;
    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        valid;
    } dii_flit;
endpackage

module ring_router_mux (
    input  logic             clk,
    input  logic             rst,
    input  dii_pkg::dii_flit in_ring,
    output logic             in_ring_ready,
    input  dii_pkg::dii_flit in_local,
    output logic             in_local_ready,
    output dii_pkg::dii_flit out_ring,
    input  logic             out_ring_ready
);
    import dii_pkg::*;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOCK_RING  = 2'd1,
        LOCK_LOCAL = 2'd2
    } state_t;

    state_t   state_reg, state_next;
    logic     prio_reg, prio_next;     // 0: ring preferred, 1: local preferred

    dii_flit  src_flit [2];            // index 0 = ring, 1 = local
    logic [1:0] grant;
    logic [1:0] src_ready;
    logic [1:0] accept;
    logic     space;
    dii_flit  sel_flit;
    logic     acc_any;
    logic     acc_last;

    assign src_flit[0] = in_ring;
    assign src_flit[1] = in_local;

    // Grant: locked source while mid-packet, otherwise arbitrate on valid and prio
    always_comb begin
        grant = 2'b00;
        case (state_reg)
            IDLE: begin
                if (in_ring.valid && !(in_local.valid && prio_reg))
                    grant = 2'b01;
                else if (in_local.valid)
                    grant = 2'b10;
            end
            LOCK_RING:  grant = 2'b01;
            LOCK_LOCAL: grant = 2'b10;
            default:    grant = 2'b00;
        endcase
    end

    // Per-source ready and handshake; readies are forced low while in reset
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_ready[gi] = grant[gi] & space & ~rst;
            assign accept[gi]    = src_ready[gi] & src_flit[gi].valid;
        end
    endgenerate

    assign in_ring_ready  = src_ready[0];
    assign in_local_ready = src_ready[1];
    assign sel_flit       = grant[1] ? in_local : in_ring;
    assign acc_any        = |accept;
    assign acc_last       = acc_any & sel_flit.last;

    // Next state and round-robin pointer update at packet boundaries
    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        case (state_reg)
            IDLE: begin
                if (acc_any && !sel_flit.last)
                    state_next = accept[1] ? LOCK_LOCAL : LOCK_RING;
            end
            LOCK_RING, LOCK_LOCAL: begin
                if (acc_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // After a last flit, point priority at the source that did not send it
        if (acc_last)
            prio_next = accept[0];
    end

    // State and priority registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
        end
    end

`ifdef RING_ROUTER_MUX_OUTREG_EN
    dii_flit out_flit_reg;

    // Space exists when the register is empty or drains this cycle
    assign space = ~out_flit_reg.valid | out_ring_ready;

    // One-entry output register: load on accept, empty on drain, hold on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            out_flit_reg <= '0;
        end else if (acc_any) begin
            out_flit_reg.data  <= sel_flit.data;
            out_flit_reg.last  <= sel_flit.last;
            out_flit_reg.valid <= 1'b1;
        end else if (out_ring_ready) begin
            out_flit_reg.valid <= 1'b0;
        end
    end

    // Output driven from the register; valid masked during reset
    always_comb begin
        out_ring       = out_flit_reg;
        out_ring.valid = out_flit_reg.valid & ~rst;
    end
`else
    assign space = out_ring_ready;

    // Output is the granted source passed straight through
    always_comb begin
        out_ring       = sel_flit;
        out_ring.valid = ((grant[0] & in_ring.valid) | (grant[1] & in_local.valid)) & ~rst;
    end
`endif

endmodule

// File: tb/tb_ring_router_mux.sv
// Self-checking bench for ring_router_mux: a directed vector table, directed
// packet sequences and a randomized run, all checked against a packet-level
// reference model (per-source expected queues, owner/priority bookkeeping).

module tb_ring_router_mux;
    import dii_pkg::*;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    dii_flit in_ring, in_local, out_ring;
    logic    in_ring_ready, in_local_ready, out_ring_ready;

    always #5 clk = ~clk;

    ring_router_mux dut (
        .clk            (clk),
        .rst            (rst),
        .in_ring        (in_ring),
        .in_ring_ready  (in_ring_ready),
        .in_local       (in_local),
        .in_local_ready (in_local_ready),
        .out_ring       (out_ring),
        .out_ring_ready (out_ring_ready)
    );

    int checks = 0;
    int errors = 0;

    // driver queues (popped on input handshake) and expected queues (popped on output)
    dii_flit     ring_q[$], local_q[$], exp_ring[$], exp_local[$];
    logic [15:0] out_log[$];
    logic [15:0] exp_list[$];

    bit ring_en, local_en, ordy, rand_mode;
    bit blk_local, hold_chk, imm_ring;
    logic [15:0] hold_data;

    // reference model state: owner 0 none / 1 ring / 2 local
    int m_owner, m_prio, m_occ, m_occ_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_pkt(input int src, input logic [15:0] base, input int n);
        dii_flit f;
        for (int i = 0; i < n; i++) begin
            f.data  = base + 16'(i);
            f.last  = (i == n - 1);
            f.valid = 1'b1;
            if (src == 1) begin ring_q.push_back(f); exp_ring.push_back(f); end
            else          begin local_q.push_back(f); exp_local.push_back(f); end
        end
    endtask

    // One clock cycle: drive at posedge+1, check and update model at negedge
    task automatic cycle();
        int g, osrc, acc;
        bit sp, rv, lv, alast;
        dii_flit ef;
        if (rand_mode) begin
            ring_en  = ($urandom_range(0, 3) != 0);
            local_en = ($urandom_range(0, 3) != 0);
            ordy     = ($urandom_range(0, 3) != 0);
        end
        in_ring  = '0;
        in_local = '0;
        if (ring_en && ring_q.size() > 0)   in_ring  = ring_q[0];
        if (local_en && local_q.size() > 0) in_local = local_q[0];
        out_ring_ready = ordy;
        @(negedge clk);
        if (out_ring.valid && out_ring_ready) out_log.push_back(out_ring.data);
        if (rst) begin
            chk("rst_ring_ready", in_ring_ready, 0);
            chk("rst_local_ready", in_local_ready, 0);
            chk("rst_out_valid", out_ring.valid, 0);
            m_owner = 0; m_prio = 0; m_occ = 0; m_occ_src = 0;
            ring_q.delete(); local_q.delete(); exp_ring.delete(); exp_local.delete();
        end else begin
            rv = in_ring.valid;
            lv = in_local.valid;
            if (m_owner != 0)           g = m_owner;
            else if (rv && !(lv && m_prio != 0)) g = 1;
            else if (lv)                g = 2;
            else                        g = 0;
`ifdef RING_ROUTER_MUX_OUTREG_EN
            sp   = (m_occ == 0) || ordy;
            osrc = (m_occ != 0) ? m_occ_src : 0;
`else
            sp   = ordy;
            osrc = (g == 1 && rv) ? 1 : ((g == 2 && lv) ? 2 : 0);
`endif
            chk("ring_ready", in_ring_ready, (g == 1) && sp);
            chk("local_ready", in_local_ready, (g == 2) && sp);
            chk("out_valid", out_ring.valid, osrc != 0);
            if (osrc != 0) begin
                if ((osrc == 1 ? exp_ring.size() : exp_local.size()) == 0) begin
                    chk("out_unexpected_flit", 1, 0);
                end else begin
                    ef = (osrc == 1) ? exp_ring[0] : exp_local[0];
                    chk("out_data", out_ring.data, ef.data);
                    chk("out_last", out_ring.last, ef.last);
                    if (ordy) begin
                        if (osrc == 1) void'(exp_ring.pop_front());
                        else           void'(exp_local.pop_front());
                    end
                end
            end
            acc   = (sp && g == 1 && rv) ? 1 : ((sp && g == 2 && lv) ? 2 : 0);
            alast = (acc == 1) ? in_ring.last : in_local.last;
            if (acc != 0) begin
                if (alast) begin m_owner = 0; m_prio = (acc == 1); end
                else       m_owner = acc;
            end
            if (acc != 0)  begin m_occ = 1; m_occ_src = acc; end
            else if (ordy) m_occ = 0;
            if (blk_local) begin
                chk("blk_local_ready", in_local_ready, 0);
                chk("blk_no_local_out", out_ring.valid && out_ring.data == 16'h4001, 0);
            end
            if (hold_chk) begin
                chk("hold_valid", out_ring.valid, 1);
                chk("hold_data", out_ring.data, hold_data);
                chk("hold_ring_ready", in_ring_ready, 0);
            end
            if (imm_ring) chk("post_rst_ring_grant", in_ring_ready, 1);
            if (in_ring.valid && in_ring_ready && ring_q.size() > 0)    void'(ring_q.pop_front());
            if (in_local.valid && in_local_ready && local_q.size() > 0) void'(local_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int limit, input string name);
        int n = 0;
        while ((ring_q.size() + local_q.size() + exp_ring.size() + exp_local.size()) != 0 && n < limit) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d_cycles required=drained", name, n);
        end
    endtask

    task automatic check_log(input string name);
        chk({name, "_count"}, out_log.size(), exp_list.size());
        for (int i = 0; i < exp_list.size() && i < out_log.size(); i++)
            chk({name, "_order"}, out_log[i], exp_list[i]);
        out_log.delete();
        exp_list.delete();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out_log.delete();
    endtask

    typedef struct {
        logic        rv, lv, ordy;
        logic        exp_rr, exp_lr, exp_ov;
        logic [15:0] exp_od;
    } vec_t;
    vec_t vecs[7];

    initial begin
        // single-flit arbitration table starting from reset (IDLE, prio=0)
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1100};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h9101};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1102};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1103};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h9105};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1106};

        in_ring = '0; in_local = '0; out_ring_ready = 1'b1;
        ring_en = 0; local_en = 0; ordy = 1; rand_mode = 0;
        blk_local = 0; hold_chk = 0; imm_ring = 0; hold_data = '0;
        m_owner = 0; m_prio = 0; m_occ = 0; m_occ_src = 0;

        // reset with both sources offering: everything must stay quiet
        rst = 1'b1;
        in_ring  = '{data: 16'h1111, last: 1'b0, valid: 1'b1};
        in_local = '{data: 16'h2222, last: 1'b0, valid: 1'b1};
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_ring_ready", in_ring_ready, 0);
        chk("reset_local_ready", in_local_ready, 0);
        chk("reset_out_valid", out_ring.valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            in_ring  = '{data: 16'h1100 + 16'(i), last: 1'b1, valid: vecs[i].rv};
            in_local = '{data: 16'h9100 + 16'(i), last: 1'b1, valid: vecs[i].lv};
            out_ring_ready = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_ring_ready", i), in_ring_ready, vecs[i].exp_rr);
            chk($sformatf("vec%0d_local_ready", i), in_local_ready, vecs[i].exp_lr);
`ifndef RING_ROUTER_MUX_OUTREG_EN
            chk($sformatf("vec%0d_out_valid", i), out_ring.valid, vecs[i].exp_ov);
            if (vecs[i].exp_ov) chk($sformatf("vec%0d_out_data", i), out_ring.data, vecs[i].exp_od);
`endif
            @(posedge clk); #1;
        end
        $display("table: %0d vectors applied", 7);

        // two competing 3-flit packets: ring first, then local, no interleave
        reset_pulse();
        push_pkt(1, 16'h1001, 3);
        push_pkt(2, 16'h2001, 3);
        ring_en = 1; local_en = 1; ordy = 1;
        drain(100, "two_packets");
        exp_list = '{16'h1001, 16'h1002, 16'h1003, 16'h2001, 16'h2002, 16'h2003};
        check_log("two_packets");
        $display("seq two_packets done checks=%0d", checks);

        // continuous single-flit packets alternate ring/local
        for (int n = 0; n < 6; n++) begin
            push_pkt(1, 16'hA000 + 16'(n), 1);
            push_pkt(2, 16'hB000 + 16'(n), 1);
            exp_list.push_back(16'hA000 + 16'(n));
            exp_list.push_back(16'hB000 + 16'(n));
        end
        drain(100, "alternate");
        check_log("alternate");
        $display("seq alternate done checks=%0d", checks);

        // ring locked after flit 1 of 4, ring goes idle while local waits
        push_pkt(1, 16'h3001, 4);
        push_pkt(2, 16'h4001, 1);
        ring_en = 1; local_en = 0;
        cycle();
        ring_en = 0; local_en = 1; blk_local = 1;
        for (int i = 0; i < 5; i++) cycle();
        ring_en = 1;
        while (ring_q.size() != 0 && checks < 100000) cycle();
        blk_local = 0;
        drain(100, "ring_lock");
        exp_list = '{16'h3001, 16'h3002, 16'h3003, 16'h3004, 16'h4001};
        check_log("ring_lock");
        $display("seq ring_lock done checks=%0d", checks);

        // downstream stall for 4 cycles mid-packet
        push_pkt(1, 16'h5001, 6);
        ring_en = 1; local_en = 0; ordy = 1;
        cycle();
        cycle();
        ordy = 0; hold_chk = 1;
`ifdef RING_ROUTER_MUX_OUTREG_EN
        hold_data = 16'h5002;
`else
        hold_data = 16'h5003;
`endif
        for (int i = 0; i < 4; i++) cycle();
        hold_chk = 0; ordy = 1;
        drain(100, "stall");
        exp_list = '{16'h5001, 16'h5002, 16'h5003, 16'h5004, 16'h5005, 16'h5006};
        check_log("stall");
        $display("seq stall done checks=%0d", checks);

        // reset while locked on local after flit 2 of 5
        push_pkt(2, 16'h6001, 5);
        ring_en = 0; local_en = 1; ordy = 1;
        cycle();
        cycle();
        reset_pulse();
        push_pkt(1, 16'h7001, 1);
        ring_en = 1; local_en = 0; imm_ring = 1;
        cycle();
        imm_ring = 0;
        drain(100, "reset_mid");
        exp_list = '{16'h7001};
        check_log("reset_mid");
        $display("seq reset_mid done checks=%0d", checks);

        // randomized traffic against the reference model
        for (int p = 0; p < 30; p++) begin
            push_pkt(1, 16'($urandom_range(0, 16'hFFF0)), int'($urandom_range(1, 4)));
            push_pkt(2, 16'($urandom_range(0, 16'hFFF0)), int'($urandom_range(1, 4)));
        end
        rand_mode = 1;
        drain(3000, "random");
        rand_mode = 0;
        $display("random phase: %0d flits out", out_log.size());
        out_log.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
